regfile_2w2r_sb: RTL and testbench

- Parametrised successor to the single-port-write register file of the single-cycle CPU.
- Two write ports, two read ports, optional write-to-read bypass, hardwired-zero register option.
- Per-register busy scoreboard for the pipelined datapath:
  - the decode stage marks a destination register busy at issue;
  - the writeback stage clears it.
- Sits between decode (read/issue) and writeback (write) in the pipelined core.

---
 rtl/regfile_2w2r_sb_if.sv | 35 +++
 rtl/regfile_2w2r_sb.sv | 119 +++++++++++
 tb/tb_regfile_2w2r_sb.sv | 288 ++++++++++++++++++++++++++++
 3 files changed

// File: rtl/regfile_2w2r_sb_if.sv
// Bus bundle for the dual-write, dual-read register file with busy scoreboard.
// The master side is the decode/writeback pipeline. The slave side is the register file.
interface regfile_2w2r_sb_if #(
  parameter int DATA_W = 32,
  parameter int ADDR_W = 5
);
  logic              we0;
  logic [ADDR_W-1:0] waddr0;
  logic [DATA_W-1:0] wdata0;
  logic              we1;
  logic [ADDR_W-1:0] waddr1;
  logic [DATA_W-1:0] wdata1;
  logic [ADDR_W-1:0] raddr0;
  logic [ADDR_W-1:0] raddr1;
  logic [DATA_W-1:0] rdata0;
  logic [DATA_W-1:0] rdata1;
  logic              busy0;
  logic              busy1;
  logic              issue_vld;
  logic [ADDR_W-1:0] issue_rd;
  logic              wr_collide;
  logic              busy_any;

  modport master (
    output we0, waddr0, wdata0, we1, waddr1, wdata1,
    output raddr0, raddr1, issue_vld, issue_rd,
    input  rdata0, rdata1, busy0, busy1, wr_collide, busy_any
  );

  modport slave (
    input  we0, waddr0, wdata0, we1, waddr1, wdata1,
    input  raddr0, raddr1, issue_vld, issue_rd,
    output rdata0, rdata1, busy0, busy1, wr_collide, busy_any
  );
endinterface

// File: rtl/regfile_2w2r_sb.sv
// Register file with two write ports and two read ports, plus a per-register busy scoreboard.
// Write port 1 wins on an address clash. Reads are combinational and can bypass same-cycle writes.
module regfile_2w2r_sb #(
  parameter int DATA_W   = 32,
  parameter int ADDR_W   = 5,
  parameter int ZERO_REG = 1,
  parameter int BYPASS   = 1
) (
  input logic              clk,
  input logic              rst,
  regfile_2w2r_sb_if.slave rf
);
  localparam int NREG = 1 << ADDR_W;

  logic [DATA_W-1:0] regs_q [NREG];
  logic [NREG-1:0]   busy_q;
  logic [NREG-1:0]   busy_d;
  logic              wr_collide_q;
  logic              wr_collide_d;
  logic              wen0_s;
  logic              wen1_s;
  logic              issue_s;
  logic              byp_s;
  logic              hit00_s;
  logic              hit01_s;
  logic              hit10_s;
  logic              hit11_s;
  logic [DATA_W-1:0] rdata0_s;
  logic [DATA_W-1:0] rdata1_s;
  logic              busy0_s;
  logic              busy1_s;

  function automatic logic is_zero_reg(input logic [ADDR_W-1:0] a);
    return (ZERO_REG != 0) && (a == '0);
  endfunction

  // Effective write/issue strobes. hitRW_s means read port R matches write port W.
  always_comb begin
    wen0_s       = rf.we0 && !is_zero_reg(rf.waddr0);
    wen1_s       = rf.we1 && !is_zero_reg(rf.waddr1);
    issue_s      = rf.issue_vld && !is_zero_reg(rf.issue_rd);
    byp_s        = (BYPASS != 0) && !rst;
    wr_collide_d = wen0_s && wen1_s && (rf.waddr0 == rf.waddr1);
    hit00_s      = wen0_s && (rf.waddr0 == rf.raddr0);
    hit01_s      = wen1_s && (rf.waddr1 == rf.raddr0);
    hit10_s      = wen0_s && (rf.waddr0 == rf.raddr1);
    hit11_s      = wen1_s && (rf.waddr1 == rf.raddr1);
  end

  // Scoreboard next state: issue beats a same-cycle write to the same register.
  always_comb begin
    busy_d = busy_q;
    for (int i = 0; i < NREG; i++) begin
      busy_d[i] = (issue_s && (rf.issue_rd == ADDR_W'(i))) ? 1'b1 :
                  ((wen0_s && (rf.waddr0 == ADDR_W'(i))) ||
                   (wen1_s && (rf.waddr1 == ADDR_W'(i)))) ? 1'b0 : busy_q[i];
    end
  end

  // Read muxes: the zero register overrides bypass, and bypass is suppressed while in reset.
  always_comb begin
    rdata0_s = regs_q[rf.raddr0];
    rdata1_s = regs_q[rf.raddr1];
    if (is_zero_reg(rf.raddr0)) begin
      rdata0_s = '0;
    end else if (byp_s && hit01_s) begin
      rdata0_s = rf.wdata1;
    end else if (byp_s && hit00_s) begin
      rdata0_s = rf.wdata0;
    end else begin
      rdata0_s = regs_q[rf.raddr0];
    end
    if (is_zero_reg(rf.raddr1)) begin
      rdata1_s = '0;
    end else if (byp_s && hit11_s) begin
      rdata1_s = rf.wdata1;
    end else if (byp_s && hit10_s) begin
      rdata1_s = rf.wdata0;
    end else begin
      rdata1_s = regs_q[rf.raddr1];
    end
    busy0_s = (byp_s && (hit00_s || hit01_s)) ? 1'b0 : busy_q[rf.raddr0];
    busy1_s = (byp_s && (hit10_s || hit11_s)) ? 1'b0 : busy_q[rf.raddr1];
  end

  // Register array. Port 1 is written last, so it wins on an address clash.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < NREG; i++) begin
        regs_q[i] <= '0;
      end
    end else begin
      if (wen0_s) begin
        regs_q[rf.waddr0] <= rf.wdata0;
      end
      if (wen1_s) begin
        regs_q[rf.waddr1] <= rf.wdata1;
      end
    end
  end

  // Scoreboard and collision flag state.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      busy_q       <= '0;
      wr_collide_q <= 1'b0;
    end else begin
      busy_q       <= busy_d;
      wr_collide_q <= wr_collide_d;
    end
  end

  assign rf.rdata0     = rdata0_s;
  assign rf.rdata1     = rdata1_s;
  assign rf.busy0      = busy0_s;
  assign rf.busy1      = busy1_s;
  assign rf.wr_collide = wr_collide_q;
  assign rf.busy_any   = |busy_q;
endmodule

// File: tb/tb_regfile_2w2r_sb.sv
// Directed bench for regfile_2w2r_sb. The stimulus side queues hand-computed expectations.
// A negedge monitor pops each expectation and compares it with the DUT output.
module tb_regfile_2w2r_sb;
  logic clk;
  logic rst;
  int   checks;
  int   failures;

  string       name_q[$];
  int          sel_q[$];
  logic [31:0] val_q[$];

  regfile_2w2r_sb_if #(.DATA_W(32), .ADDR_W(5)) m_if ();
  regfile_2w2r_sb_if #(.DATA_W(32), .ADDR_W(5)) n_if ();
  regfile_2w2r_sb_if #(.DATA_W(16), .ADDR_W(3)) s_if ();

  regfile_2w2r_sb #(.DATA_W(32), .ADDR_W(5), .ZERO_REG(1), .BYPASS(1)) u_main (
    .clk(clk), .rst(rst), .rf(m_if)
  );
  regfile_2w2r_sb #(.DATA_W(32), .ADDR_W(5), .ZERO_REG(1), .BYPASS(0)) u_nobyp (
    .clk(clk), .rst(rst), .rf(n_if)
  );
  regfile_2w2r_sb #(.DATA_W(16), .ADDR_W(3), .ZERO_REG(0), .BYPASS(1)) u_small (
    .clk(clk), .rst(rst), .rf(s_if)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [31:0] actual(input int sel);
    case (sel)
      0:       return m_if.rdata0;
      1:       return m_if.rdata1;
      2:       return {31'd0, m_if.busy0};
      3:       return {31'd0, m_if.busy1};
      4:       return {31'd0, m_if.wr_collide};
      5:       return {31'd0, m_if.busy_any};
      6:       return n_if.rdata0;
      7:       return {16'd0, s_if.rdata0};
      8:       return {16'd0, s_if.rdata1};
      9:       return {31'd0, s_if.busy0};
      default: return 32'hFFFF_FFFF;
    endcase
  endfunction

  function automatic logic [15:0] pat(input int i);
    return 16'(32'h1111 * (i + 1));
  endfunction

  task automatic expect_v(input string n, input int sel, input logic [31:0] v);
    name_q.push_back(n);
    sel_q.push_back(sel);
    val_q.push_back(v);
  endtask

  task automatic check_now(input string n, input int sel, input logic [31:0] v);
    logic [31:0] a;
    a = actual(sel);
    checks++;
    if (a !== v) begin
      failures++;
      $display("FAIL %s: actual=%h expected=%h", n, a, v);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    m_if.we0 = 1'b0; m_if.waddr0 = '0; m_if.wdata0 = '0;
    m_if.we1 = 1'b0; m_if.waddr1 = '0; m_if.wdata1 = '0;
    m_if.raddr0 = '0; m_if.raddr1 = '0; m_if.issue_vld = 1'b0; m_if.issue_rd = '0;
    n_if.we0 = 1'b0; n_if.waddr0 = '0; n_if.wdata0 = '0;
    n_if.we1 = 1'b0; n_if.waddr1 = '0; n_if.wdata1 = '0;
    n_if.raddr0 = '0; n_if.raddr1 = '0; n_if.issue_vld = 1'b0; n_if.issue_rd = '0;
    s_if.we0 = 1'b0; s_if.waddr0 = '0; s_if.wdata0 = '0;
    s_if.we1 = 1'b0; s_if.waddr1 = '0; s_if.wdata1 = '0;
    s_if.raddr0 = '0; s_if.raddr1 = '0; s_if.issue_vld = 1'b0; s_if.issue_rd = '0;
  endtask

  task automatic collide_m(input logic [4:0] a, input logic [31:0] d0, input logic [31:0] d1);
    m_if.we0 = 1'b1; m_if.waddr0 = a; m_if.wdata0 = d0;
    m_if.we1 = 1'b1; m_if.waddr1 = a; m_if.wdata1 = d1;
  endtask

  // Monitor: drain every expectation queued during this cycle.
  always @(negedge clk) begin
    string       n;
    int          sel;
    logic [31:0] e;
    logic [31:0] a;
    while (sel_q.size() != 0) begin
      n   = name_q.pop_front();
      sel = sel_q.pop_front();
      e   = val_q.pop_front();
      a   = actual(sel);
      checks++;
      if (a !== e) begin
        failures++;
        $display("FAIL %s: actual=%h expected=%h", n, a, e);
      end
    end
  end

  // Watchdog: flag a hung simulation.
  initial begin
    #200000;
    failures++;
    $display("FAIL timeout: simulation did not finish");
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    checks   = 0;
    failures = 0;
    rst      = 1'b1;
    idle();
    tick();
    check_now("rst_busy0_now", 2, 32'h0);
    check_now("rst_rdata1_now", 1, 32'h0);
    expect_v("rst_rdata0", 0, 32'h0);
    expect_v("rst_busy_any", 5, 32'h0);
    expect_v("rst_wr_collide", 4, 32'h0);
    tick();
    rst = 1'b0;

    // 1. All registers read zero and not busy after reset.
    for (int r = 0; r < 32; r++) begin
      tick(); idle();
      m_if.raddr0 = 5'(r); m_if.raddr1 = 5'(31 - r);
      expect_v("init_rdata0", 0, 32'h0);
      expect_v("init_rdata1", 1, 32'h0);
      expect_v("init_busy0", 2, 32'h0);
      expect_v("init_busy1", 3, 32'h0);
    end
    expect_v("init_busy_any", 5, 32'h0);

    // Collide on r5 twice and issue r10, then assert reset in the middle of a cycle.
    tick(); idle();
    collide_m(5'd5, 32'h5A, 32'hA5); m_if.issue_vld = 1'b1; m_if.issue_rd = 5'd10;
    m_if.raddr0 = 5'd5;
    expect_v("r5_bypass", 0, 32'hA5);
    tick(); idle();
    collide_m(5'd5, 32'h5A, 32'hA5); m_if.issue_vld = 1'b1; m_if.issue_rd = 5'd10;
    m_if.raddr0 = 5'd5;
    expect_v("r5_stored", 0, 32'hA5);
    expect_v("r5_collide", 4, 32'h1);
    expect_v("r10_busy_any", 5, 32'h1);
    tick(); idle();
    m_if.raddr0 = 5'd5;
    rst = 1'b1;
    #1;
    check_now("async_rst_rdata_now", 0, 32'h0);
    expect_v("async_rst_rdata", 0, 32'h0);
    expect_v("async_rst_collide", 4, 32'h0);
    expect_v("async_rst_busy_any", 5, 32'h0);
    tick();
    rst = 1'b0;
    expect_v("post_rst_rdata", 0, 32'h0);

    // 2. Dual write to r3 (port 1 wins), collision pulse, and zero-register collision.
    tick(); idle();
    collide_m(5'd3, 32'h1111, 32'h2222);
    m_if.raddr0 = 5'd3; m_if.raddr1 = 5'd3;
    expect_v("r3_byp_rdata0", 0, 32'h2222);
    expect_v("r3_byp_rdata1", 1, 32'h2222);
    expect_v("r3_collide_pre", 4, 32'h0);
    tick(); idle();
    m_if.raddr0 = 5'd3;
    expect_v("r3_stored", 0, 32'h2222);
    expect_v("r3_collide", 4, 32'h1);
    tick(); idle();
    expect_v("r3_collide_end", 4, 32'h0);
    tick(); idle();
    collide_m(5'd0, 32'h1111, 32'h2222);
    expect_v("r0_byp", 0, 32'h0);
    tick(); idle();
    expect_v("r0_no_collide", 4, 32'h0);
    expect_v("r0_stored", 0, 32'h0);
    // Back-to-back collisions keep the flag high.
    tick(); idle();
    collide_m(5'd6, 32'h6A, 32'h6B);
    tick(); idle();
    collide_m(5'd6, 32'h6C, 32'h6D);
    expect_v("b2b_collide_1", 4, 32'h1);
    tick(); idle();
    m_if.raddr0 = 5'd6;
    expect_v("b2b_collide_2", 4, 32'h1);
    expect_v("r6_stored", 0, 32'h6D);
    tick(); idle();
    expect_v("b2b_collide_end", 4, 32'h0);
    // Two writes to different registers in the same cycle.
    tick(); idle();
    m_if.we0 = 1'b1; m_if.waddr0 = 5'd11; m_if.wdata0 = 32'h1B;
    m_if.we1 = 1'b1; m_if.waddr1 = 5'd12; m_if.wdata1 = 32'h1C;
    tick(); idle();
    m_if.raddr0 = 5'd11; m_if.raddr1 = 5'd12;
    expect_v("r11_stored", 0, 32'h1B);
    expect_v("r12_stored", 1, 32'h1C);
    expect_v("dual_no_collide", 4, 32'h0);

    // 3. Bypass on the main DUT; old-then-new read order on the no-bypass DUT.
    tick(); idle();
    n_if.we0 = 1'b1; n_if.waddr0 = 5'd7; n_if.wdata0 = 32'h1234_5678;
    tick(); idle();
    m_if.we0 = 1'b1; m_if.waddr0 = 5'd7; m_if.wdata0 = 32'hDEAD_BEEF;
    m_if.raddr0 = 5'd7; m_if.raddr1 = 5'd7;
    n_if.we0 = 1'b1; n_if.waddr0 = 5'd7; n_if.wdata0 = 32'hDEAD_BEEF;
    n_if.raddr0 = 5'd7;
    expect_v("byp_rdata0", 0, 32'hDEAD_BEEF);
    expect_v("byp_rdata1", 1, 32'hDEAD_BEEF);
    expect_v("nobyp_old", 6, 32'h1234_5678);
    tick(); idle();
    n_if.raddr0 = 5'd7;
    expect_v("nobyp_new", 6, 32'hDEAD_BEEF);

    // 4. Scoreboard set by issue, cleared by a write to the same register.
    tick(); idle();
    m_if.issue_vld = 1'b1; m_if.issue_rd = 5'd9; m_if.raddr0 = 5'd9;
    expect_v("r9_issue_same_cycle", 2, 32'h0);
    expect_v("r9_busy_any_pre", 5, 32'h0);
    tick(); idle();
    m_if.raddr0 = 5'd9;
    expect_v("r9_busy", 2, 32'h1);
    expect_v("r9_busy_any", 5, 32'h1);
    tick(); idle();
    m_if.we1 = 1'b1; m_if.waddr1 = 5'd9; m_if.wdata1 = 32'h99;
    m_if.raddr0 = 5'd9; m_if.raddr1 = 5'd9;
    expect_v("r9_busy0_byp", 2, 32'h0);
    expect_v("r9_busy1_byp", 3, 32'h0);
    expect_v("r9_busy_any_stored", 5, 32'h1);
    expect_v("r9_wr_byp", 0, 32'h99);
    tick(); idle();
    m_if.raddr0 = 5'd9;
    expect_v("r9_cleared", 2, 32'h0);
    expect_v("r9_busy_any_clr", 5, 32'h0);
    expect_v("r9_data", 0, 32'h99);

    // 5. Issue and write to r4 in the same cycle: issue wins. Issue to r0 is ignored.
    tick(); idle();
    m_if.issue_vld = 1'b1; m_if.issue_rd = 5'd4;
    m_if.we0 = 1'b1; m_if.waddr0 = 5'd4; m_if.wdata0 = 32'h4444;
    m_if.raddr0 = 5'd4;
    expect_v("r4_busy_byp", 2, 32'h0);
    tick(); idle();
    m_if.raddr0 = 5'd4;
    expect_v("r4_data", 0, 32'h4444);
    expect_v("r4_busy", 2, 32'h1);
    expect_v("r4_busy_any", 5, 32'h1);
    tick(); idle();
    m_if.we1 = 1'b1; m_if.waddr1 = 5'd4; m_if.wdata1 = 32'h4445;
    m_if.issue_vld = 1'b1; m_if.issue_rd = 5'd0;
    m_if.raddr0 = 5'd4;
    expect_v("r4_byp_p1", 0, 32'h4445);
    tick(); idle();
    m_if.raddr0 = 5'd0; m_if.raddr1 = 5'd4;
    expect_v("r0_never_busy", 2, 32'h0);
    expect_v("r4_clear", 3, 32'h0);
    expect_v("busy_any_zero", 5, 32'h0);
    expect_v("r4_data2", 1, 32'h4445);

    // 6. 16-bit x 8 instance with no zero register: each register keeps its own pattern.
    for (int c = 0; c < 4; c++) begin
      tick(); idle();
      s_if.we0 = 1'b1; s_if.waddr0 = 3'(2 * c);     s_if.wdata0 = pat(2 * c);
      s_if.we1 = 1'b1; s_if.waddr1 = 3'(2 * c + 1); s_if.wdata1 = pat(2 * c + 1);
    end
    for (int i = 0; i < 8; i++) begin
      tick(); idle();
      s_if.raddr0 = 3'(i); s_if.raddr1 = 3'(7 - i);
      expect_v("small_rdata0", 7, {16'd0, pat(i)});
      expect_v("small_rdata1", 8, {16'd0, pat(7 - i)});
    end
    tick(); idle();
    s_if.issue_vld = 1'b1; s_if.issue_rd = 3'd0;
    tick(); idle();
    s_if.raddr0 = 3'd0;
    expect_v("small_r0_busy", 9, 32'h1);

    tick(); idle();
    tick();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
